keccak_shift_register: RTL and testbench

Width-converting input buffer for the Keccak datapath. Accepts narrow words (`INPUT_BUFFER_SIZE` bits) from the message source and assembles them into one wide block (`OUTPUT_BUFFER_SIZE` bits) for the permutation core. When the block is full, it holds it and asserts `buffer_full` until the core takes it. A `last_block` word zero-pads the remainder of the block.

---
 rtl/keccak_shift_register_pkg.sv | 12 +
 rtl/keccak_shift_register.sv | 85 ++++++++
 tb/tb_keccak_shift_register.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/keccak_shift_register_pkg.sv
// Shared constants and FSM encoding for the Keccak input buffer.
package pkg_keccak;

  localparam int IN_BUF_SIZE = 32;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } buf_state_t;

endpackage

// File: rtl/keccak_shift_register.sv
// Narrow-to-wide input buffer: shifts message words into one permutation block,
// zero-pads a short final block and holds the block until the core takes it.
module keccak_shift_register
  import pkg_keccak::*;
#(
  parameter int INPUT_BUFFER_SIZE  = IN_BUF_SIZE,
  parameter int OUTPUT_BUFFER_SIZE = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [INPUT_BUFFER_SIZE-1:0]  buffer_input,
  input  logic                          input_valid,
  input  logic                          output_ready,
  input  logic                          last_block,
  output logic                          buffer_full,
  output logic [OUTPUT_BUFFER_SIZE-1:0] buffer_output
);

  localparam int WORDS = OUTPUT_BUFFER_SIZE / INPUT_BUFFER_SIZE;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  buf_state_t                    state, state_next;
  logic [CNT_W-1:0]              cnt;
  logic [OUTPUT_BUFFER_SIZE-1:0] sr;
  logic                          shift_en;
  logic                          cnt_clr;
  logic [INPUT_BUFFER_SIZE-1:0]  shift_word;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    shift_word = '0;
    case (state)
      FILL: begin
        if (input_valid) begin
          shift_en   = 1'b1;
          shift_word = buffer_input;
          if (cnt == LAST_CNT)  state_next = FULL;
          else if (last_block)  state_next = PAD;
        end
      end
      PAD: begin
        // Zero fill; the zero shifted at cnt==WORDS-1 completes the block.
        shift_en = 1'b1;
        if (cnt == LAST_CNT) state_next = FULL;
      end
      FULL: begin
        if (output_ready) begin
          state_next = FILL;
          cnt_clr    = 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  // NOTE: the block register is reset as well, since an all-zero output after
  // reset is part of the visible interface, not just a convenience.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[OUTPUT_BUFFER_SIZE-INPUT_BUFFER_SIZE-1:0], shift_word};
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
    end else if (cnt_clr) begin
      cnt <= '0;
    end
  end

  assign buffer_full   = (state == FULL);
  assign buffer_output = sr;

endmodule

// File: tb/tb_keccak_shift_register.sv
// Randomised and directed bench for keccak_shift_register against a
// word-history reference model.
module tb_keccak_shift_register;

  localparam int IW = 32;
  localparam int OW = 256;
  localparam int W  = OW / IW;

  logic          clock;
  logic          reset;
  logic [IW-1:0] buffer_input;
  logic          input_valid;
  logic          output_ready;
  logic          last_block;
  logic          buffer_full;
  logic [OW-1:0] buffer_output;

  keccak_shift_register #(
    .INPUT_BUFFER_SIZE (IW),
    .OUTPUT_BUFFER_SIZE(OW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buffer_input (buffer_input),
    .input_valid  (input_valid),
    .output_ready (output_ready),
    .last_block   (last_block),
    .buffer_full  (buffer_full),
    .buffer_output(buffer_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: the output is always the most recent W words written into
  // the block (older data simply scrolls out), zeros if fewer exist.
  logic [IW-1:0] hist[$];
  int            m_words;    // words (data or pad) in the block being built
  bit            m_padding;
  bit            m_full;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [OW-1:0] e;
    int idx;
    e = '0;
    for (int i = 0; i < W; i++) begin
      idx = hist.size() - W + i;
      if (idx >= 0) e[(W-1-i)*IW +: IW] = hist[idx];
    end
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_words   = 0;
    m_padding = 0;
    m_full    = 0;
  endtask

  task automatic model_push(input logic [IW-1:0] w);
    hist.push_back(w);
    if (hist.size() > W) void'(hist.pop_front());
    m_words++;
    if (m_words == W) begin
      m_full    = 1;
      m_padding = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [IW-1:0] w, input bit l, input bit r);
    if (m_full) begin
      if (r) begin
        m_full  = 0;
        m_words = 0;
      end
    end else if (m_padding) begin
      model_push('0);
    end else if (v) begin
      model_push(w);
      if (!m_full && l) m_padding = 1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".full"}, OW'(buffer_full), OW'(m_full));
    check({tag, ".out"}, buffer_output, model_out());
  endtask

  // One clock: drive, let the edge happen, advance the model, check just after.
  task automatic cycle(input bit v, input logic [IW-1:0] w, input bit l, input bit r,
                       input string tag);
    input_valid  = v;
    buffer_input = w;
    last_block   = l;
    output_ready = r;
    @(posedge clock);
    model_step(v, w, l, r);
    #1;
    compare_model(tag);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_full && guard < 4) begin
      cycle(1'b0, '0, 1'b0, 1'b1, "drain");
      guard++;
    end
    output_ready = 1'b0;
  endtask

  logic [IW-1:0] pat[4] = '{32'h84BE2329, 32'hAED66CE1, 32'h00000000, 32'hFFFFFFFF};
  logic [OW-1:0] exp_blk;

  initial begin
    model_reset();
    reset        = 1'b0;
    input_valid  = 1'b0;
    buffer_input = '0;
    last_block   = 1'b0;
    output_ready = 1'b0;

    // Reset held with random inputs, then released with no valid input.
    for (int i = 0; i < 3; i++) begin
      input_valid  = 1'($urandom);
      buffer_input = $urandom;
      last_block   = 1'($urandom);
      output_ready = 1'($urandom);
      @(posedge clock);
      #1;
      compare_model("in_reset");
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, $urandom, 1'b1, 1'b1, "post_reset");

    // Full-rate block; further words ignored while full.
    for (int i = 0; i < W; i++) cycle(1'b1, pat[i%4], 1'b0, 1'b0, "fill");
    exp_blk = {pat[0], pat[1], pat[2], pat[3], pat[0], pat[1], pat[2], pat[3]};
    check("full_flag", OW'(buffer_full), OW'(1));
    check("full_block", buffer_output, exp_blk);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'($urandom), 1'b0, "hold_full");
    check("hold_block", buffer_output, exp_blk);

    // One-cycle drain, then a new block with output_ready held high in FILL.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "drain_pulse");
    check("drain_flag", OW'(buffer_full), OW'(0));
    for (int i = 0; i < W; i++) cycle(1'b1, $urandom, 1'b0, 1'b1, "fill_ready_hi");
    output_ready = 1'b0;
    drain();

    // Short final block: 3 words, last on the third, 5 pad cycles.
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0, "last_w1");
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0, "last_w2");
    cycle(1'b1, 32'h33333333, 1'b1, 1'b0, "last_w3");
    for (int i = 0; i < W - 3; i++) begin
      check("pad_not_full", OW'(buffer_full), OW'(0));
      cycle(1'b1, $urandom, 1'($urandom), 1'b0, "pad");
    end
    check("pad_full_flag", OW'(buffer_full), OW'(1));
    check("pad_block", buffer_output, {96'h111111112222222233333333, 160'h0});
    drain();

    // last_block on the final word goes straight to FULL.
    for (int i = 0; i < W; i++) cycle(1'b1, $urandom, i == W - 1, 1'b0, "last_on_final");
    check("last_on_final_flag", OW'(buffer_full), OW'(1));
    cycle(1'b0, '0, 1'b0, 1'b0, "last_on_final_hold");
    drain();

    // Asynchronous reset mid-block discards everything.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, "pre_reset");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_model("async_reset");
    #1;
    reset = 1'b1;
    for (int i = 0; i < W; i++) cycle(1'b1, 32'hA0000000 + i, 1'b0, 1'b0, "after_reset");
    check("clean_block", buffer_output,
          {32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
           32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007});
    drain();

    // Gapped valid: only valid cycles shift.
    for (int i = 0; i < 2 * W; i++) cycle(i % 2 == 0, $urandom, 1'b0, 1'b0, "gapped");
    check("gapped_full", OW'(buffer_full), OW'(1));
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 3, "random");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
